byte_demultiplexer: RTL and testbench

Responder at the far end of the 8-bit expansion bus. Accepts byte-wide cycles (odd byte first, even second, as driven by the CPU-side 16→8 multiplexer) and converts them into 16-bit word accesses on a req/ack memory port. Read pairs cost one word fetch. Write pairs merge into one full-word write. Unpaired bytes become byte-enabled writes.

---
 rtl/byte_demux_pkg.sv | 19 +
 rtl/byte_demultiplexer.sv | 214 +++++++++++++++++++++
 tb/tb_byte_demultiplexer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/byte_demux_pkg.sv
// Shared types and constants for the byte-wide expansion-bus responder.
//   state_e  : responder FSM states
//   BE_*     : byte-enable codes, indexed [0:1] with be[0] = bits 0:7 (even),
//              be[1] = bits 8:15 (odd)
package byte_demux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  localparam logic [0:1] BE_WORD = 2'b11;
  localparam logic [0:1] BE_EVEN = 2'b10;
  localparam logic [0:1] BE_ODD  = 2'b01;

endpackage

// File: rtl/byte_demultiplexer.sv
// Far-end responder of the 8-bit expansion bus. Byte cycles (odd byte first,
// even second) are turned into 16-bit word accesses on a req/ack port.
// Read pairs share one word fetch, write pairs merge into one full-word
// write, and a stranded odd byte is flushed as a byte-enabled write.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   memen8, we8, a8, a15  : bus cycle strobe, direction, word addr, byte select
//   d8 / q8               : bus write data / registered bus read data
//   rdy8                  : bus ready (0 = wait state), combinational
//   mem_req/we/addr/be/d  : word request side, held until mem_ack
//   mem_q, mem_ack        : word read data and completion
module byte_demultiplexer
  import byte_demux_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memen8,
  input  logic        we8,
  input  logic [0:14] a8,
  input  logic        a15,
  input  logic [0:7]  d8,
  output logic [0:7]  q8,
  output logic        rdy8,
  output logic        mem_req,
  output logic        mem_we,
  output logic [0:14] mem_addr,
  output logic [0:1]  mem_be,
  output logic [0:15] mem_d,
  input  logic [0:15] mem_q,
  input  logic        mem_ack
);

  state_e      state_q;
  logic        memen8_q;
  logic [0:15] word_latch_q;
  logic [0:14] latch_addr_q;
  logic        rd_valid_q;
  logic        odd_pend_q;
  // Set after the flush ack: the captured access is issued next cycle, which
  // gives the one-cycle gap on mem_req between the two requests.
  logic        issue_q;

  logic        cap_we_q;
  logic        cap_odd_q;
  logic [0:14] cap_addr_q;
  logic [0:7]  cap_d_q;

  logic [0:7]  q8_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [0:14] mem_addr_q;
  logic [0:1]  mem_be_q;
  logic [0:15] mem_d_q;

  logic        start;
  logic        need_flush;
  logic        issue;
  logic        ack;
  logic        acc_we;
  logic        acc_odd;
  logic [0:14] acc_addr;
  logic [0:7]  acc_d;
  logic        rd_hit;
  logic        wr_pair;
  state_e      state_end;

  assign start = memen8 & ~memen8_q & (state_q == ST_IDLE);

  // Only an even write to the latched word may complete a pending odd byte;
  // anything else must push it out first.
  assign need_flush = odd_pend_q & ~(we8 & ~a15 & (a8 == latch_addr_q));

  assign issue = (start & ~need_flush) | ((state_q == ST_FLUSH) & issue_q);
  assign ack   = mem_req_q & mem_ack;

  // The access being processed: live bus at start, captured copy after a flush.
  assign acc_we   = start ? we8 : cap_we_q;
  assign acc_odd  = start ? a15 : cap_odd_q;
  assign acc_addr = start ? a8  : cap_addr_q;
  assign acc_d    = start ? d8  : cap_d_q;

  assign rd_hit  = rd_valid_q & (acc_addr == latch_addr_q);
  assign wr_pair = odd_pend_q & (acc_addr == latch_addr_q);

  // If the bus cycle already ended, skip DONE and return straight to IDLE.
  assign state_end = memen8 ? ST_DONE : ST_IDLE;

  assign rdy8 = ~(start | (state_q == ST_FLUSH) | (state_q == ST_RD_WAIT) |
                  (state_q == ST_WR_WAIT));

  assign q8       = q8_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be   = mem_be_q;
  assign mem_d    = mem_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      memen8_q     <= 1'b1;  // a cycle in flight at reset release is ignored
      word_latch_q <= '0;
      latch_addr_q <= '0;
      rd_valid_q   <= 1'b0;
      odd_pend_q   <= 1'b0;
      issue_q      <= 1'b0;
      cap_we_q     <= 1'b0;
      cap_odd_q    <= 1'b0;
      cap_addr_q   <= '0;
      cap_d_q      <= '0;
      q8_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_d_q      <= '0;
    end else begin
      memen8_q <= memen8;

      if (start) begin
        cap_we_q   <= we8;
        cap_odd_q  <= a15;
        cap_addr_q <= a8;
        cap_d_q    <= d8;
      end

      if (issue) begin
        issue_q <= 1'b0;
        if (!acc_we) begin
          if (!acc_odd && rd_hit) begin
            // Second half of a read pair: served from the latch.
            if (memen8) q8_q <= word_latch_q[0:7];
            rd_valid_q <= 1'b0;
            state_q    <= state_end;
          end else begin
            state_q    <= ST_RD_WAIT;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= acc_addr;
            mem_be_q   <= BE_WORD;
          end
        end else if (acc_odd) begin
          // Odd write is only parked; it goes out with the even byte or a flush.
          word_latch_q[8:15] <= acc_d;
          latch_addr_q       <= acc_addr;
          odd_pend_q         <= 1'b1;
          rd_valid_q         <= 1'b0;
          state_q            <= state_end;
        end else begin
          rd_valid_q <= 1'b0;
          state_q    <= ST_WR_WAIT;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b1;
          mem_addr_q <= acc_addr;
          if (wr_pair) begin
            mem_be_q <= BE_WORD;
            mem_d_q  <= {acc_d, word_latch_q[8:15]};
          end else begin
            mem_be_q <= BE_EVEN;
            mem_d_q  <= {acc_d, 8'h00};
          end
        end
      end else if (start) begin
        // start without issue means a flush is needed first.
        if (we8) rd_valid_q <= 1'b0;
        state_q    <= ST_FLUSH;
        issue_q    <= 1'b0;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b1;
        mem_addr_q <= latch_addr_q;
        mem_be_q   <= BE_ODD;
        mem_d_q    <= {8'h00, word_latch_q[8:15]};
      end else begin
        unique case (state_q)
          ST_FLUSH: begin
            if (ack) begin
              mem_req_q  <= 1'b0;
              odd_pend_q <= 1'b0;
              issue_q    <= 1'b1;
            end
          end
          ST_RD_WAIT: begin
            if (ack) begin
              mem_req_q <= 1'b0;
              if (cap_odd_q) begin
                // Latch update applies even if the bus cycle was abandoned.
                word_latch_q <= mem_q;
                latch_addr_q <= mem_addr_q;
                rd_valid_q   <= 1'b1;
                if (memen8) q8_q <= mem_q[8:15];
              end else if (memen8) begin
                q8_q <= mem_q[0:7];
              end
              state_q <= state_end;
            end
          end
          ST_WR_WAIT: begin
            if (ack) begin
              mem_req_q <= 1'b0;
              if (mem_be_q == BE_WORD) odd_pend_q <= 1'b0;
              state_q <= state_end;
            end
          end
          ST_DONE: begin
            if (!memen8) state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_demultiplexer.sv
// Bench for byte_demultiplexer: table of bus byte cycles with expected q8,
// latency and memory requests; expected requests are queued when a cycle is
// driven and checked by the memory responder as each request appears.
module tb_byte_demultiplexer;

  typedef struct {
    logic        we;
    logic [0:14] addr;
    logic [0:1]  be;
    logic [0:15] d;
  } req_t;

  typedef struct {
    logic        we;
    logic [0:14] a;
    logic        odd;
    logic [0:7]  d;
    logic [0:15] memq;
    int          dly;
    logic [0:7]  q;
    int          lat;
    int          nreq;
    req_t        r0;
    req_t        r1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memen8 = 1'b0;
  logic        we8 = 1'b0;
  logic [0:14] a8 = '0;
  logic        a15 = 1'b0;
  logic [0:7]  d8 = '0;
  logic [0:7]  q8;
  logic        rdy8;
  logic        mem_req;
  logic        mem_we;
  logic [0:14] mem_addr;
  logic [0:1]  mem_be;
  logic [0:15] mem_d;
  logic [0:15] mem_q = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  req_t        exp_q[$];
  int          ack_dly = 0;
  logic [0:15] mem_rdata = '0;
  int          wait_cnt = 0;
  logic        in_req = 1'b0;
  int          last_ack_cyc = -100;
  int          last_gap = 0;
  logic [0:33] snap;

  byte_demultiplexer dut (
    .clk(clk), .reset(reset), .memen8(memen8), .we8(we8), .a8(a8), .a15(a15),
    .d8(d8), .q8(q8), .rdy8(rdy8), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_d(mem_d), .mem_q(mem_q),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder and request scoreboard.
  always @(negedge clk) begin
    req_t e;
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      in_req  = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else begin
      if (!in_req) begin
        in_req   = 1'b1;
        wait_cnt = 0;
        last_gap = cyc - last_ack_cyc - 1;
        snap     = {mem_we, mem_addr, mem_be, mem_d};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected actual addr=%0h be=%0b required no request", mem_addr, mem_be);
        end else begin
          e = exp_q.pop_front();
          chk("req_we", mem_we, e.we);
          chk("req_addr", mem_addr, e.addr);
          chk("req_be", mem_be, e.be);
          if (e.we) chk("req_d", mem_d, e.d);
        end
      end
      if (wait_cnt >= ack_dly) begin
        chk("req_stable", {mem_we, mem_addr, mem_be, mem_d}, snap);
        mem_ack      = 1'b1;
        mem_q        = mem_rdata;
        last_ack_cyc = cyc;
      end else begin
        wait_cnt++;
      end
    end
  end

  // One bus byte cycle; called at a negedge, returns at a negedge.
  task automatic bus_op(input logic we, input logic [0:14] a, input logic odd,
                        input logic [0:7] d, output logic [0:7] q, output int lat);
    memen8 = 1'b1; we8 = we; a8 = a; a15 = odd; d8 = d;
    #1;
    chk("rdy8_start", rdy8, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy8 && lat < 50);
    if (!rdy8) chk("rdy8_timeout", rdy8, 1'b1);
    q = q8;
    memen8 = 1'b0; we8 = 1'b0; d8 = '0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v[15];
    req_t       nr;
    logic [0:7] q;
    int         lat;

    nr = '{1'b0, 15'h0, 2'b00, 16'h0};
    //       we    addr      odd   d      memq      dly q      lat nreq r0 / r1
    v[0]  = '{1'b0, 15'h0123, 1'b1, 8'h00, 16'hA55A, 0, 8'h5A, 2, 1, '{1'b0, 15'h0123, 2'b11, 16'h0}, nr};
    v[1]  = '{1'b0, 15'h0123, 1'b0, 8'h00, 16'h0000, 0, 8'hA5, 1, 0, nr, nr};
    v[2]  = '{1'b1, 15'h0040, 1'b1, 8'h34, 16'h0000, 0, 8'h00, 1, 0, nr, nr};
    v[3]  = '{1'b1, 15'h0040, 1'b0, 8'h12, 16'h0000, 0, 8'h00, 2, 1, '{1'b1, 15'h0040, 2'b11, 16'h1234}, nr};
    v[4]  = '{1'b1, 15'h0010, 1'b1, 8'h77, 16'h0000, 0, 8'h00, 1, 0, nr, nr};
    v[5]  = '{1'b0, 15'h0020, 1'b0, 8'h00, 16'hBEEF, 0, 8'hBE, 4, 2, '{1'b1, 15'h0010, 2'b01, 16'h0077},
                                                                 '{1'b0, 15'h0020, 2'b11, 16'h0}};
    v[6]  = '{1'b1, 15'h0005, 1'b0, 8'hEE, 16'h0000, 5, 8'h00, 7, 1, '{1'b1, 15'h0005, 2'b10, 16'hEE00}, nr};
    v[7]  = '{1'b0, 15'h0123, 1'b0, 8'h00, 16'h1357, 0, 8'h13, 2, 1, '{1'b0, 15'h0123, 2'b11, 16'h0}, nr};
    v[8]  = '{1'b0, 15'h0200, 1'b1, 8'h00, 16'hC0DE, 0, 8'hDE, 2, 1, '{1'b0, 15'h0200, 2'b11, 16'h0}, nr};
    v[9]  = '{1'b1, 15'h0300, 1'b1, 8'h99, 16'h0000, 0, 8'h00, 1, 0, nr, nr};
    v[10] = '{1'b0, 15'h0200, 1'b0, 8'h00, 16'h4455, 0, 8'h44, 4, 2, '{1'b1, 15'h0300, 2'b01, 16'h0099},
                                                                 '{1'b0, 15'h0200, 2'b11, 16'h0}};
    v[11] = '{1'b1, 15'h0400, 1'b1, 8'hAB, 16'h0000, 0, 8'h00, 1, 0, nr, nr};
    v[12] = '{1'b1, 15'h0401, 1'b0, 8'hCD, 16'h0000, 0, 8'h00, 4, 2, '{1'b1, 15'h0400, 2'b01, 16'h00AB},
                                                                 '{1'b1, 15'h0401, 2'b10, 16'hCD00}};
    v[13] = '{1'b0, 15'h0500, 1'b1, 8'h00, 16'h1122, 2, 8'h22, 4, 1, '{1'b0, 15'h0500, 2'b11, 16'h0}, nr};
    v[14] = '{1'b0, 15'h0501, 1'b0, 8'h00, 16'h3344, 0, 8'h33, 2, 1, '{1'b0, 15'h0501, 2'b11, 16'h0}, nr};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_rdy8", rdy8, 1'b1);
    chk("reset_req", mem_req, 1'b0);
    chk("reset_we", mem_we, 1'b0);
    chk("reset_q8", q8, 8'h00);
    chk("reset_addr", mem_addr, 15'h0);
    chk("reset_be", mem_be, 2'b00);
    chk("reset_d", mem_d, 16'h0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      ack_dly   = v[i].dly;
      mem_rdata = v[i].memq;
      if (v[i].nreq > 0) exp_q.push_back(v[i].r0);
      if (v[i].nreq > 1) exp_q.push_back(v[i].r1);
      bus_op(v[i].we, v[i].a, v[i].odd, v[i].d, q, lat);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      if (!v[i].we) chk($sformatf("v%0d_q8", i), q, v[i].q);
      chk($sformatf("v%0d_reqs_left", i), exp_q.size(), 0);
      if (v[i].nreq == 2) chk($sformatf("v%0d_flush_gap", i), last_gap, 1);
      exp_q.delete();
    end

    // Reset while a read is waiting on the memory, bus cycle still active.
    ack_dly   = 100;
    mem_rdata = 16'h0;
    exp_q.push_back('{1'b0, 15'h0700, 2'b11, 16'h0});
    memen8 = 1'b1; we8 = 1'b0; a8 = 15'h0700; a15 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pre_req", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_rdy8", rdy8, 1'b1);
    chk("rst_q8", q8, 8'h00);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_nostart_rdy8", rdy8, 1'b1);
      chk("rst_nostart_req", mem_req, 1'b0);
    end
    memen8 = 1'b0;
    @(negedge clk);
    exp_q.delete();
    ack_dly   = 0;
    mem_rdata = 16'h6789;
    exp_q.push_back('{1'b0, 15'h0700, 2'b11, 16'h0});
    bus_op(1'b0, 15'h0700, 1'b1, 8'h00, q, lat);
    chk("rst_after_latency", lat, 2);
    chk("rst_after_q8", q, 8'h89);
    chk("rst_after_reqs_left", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
